// File: rtl/spi_key_slave.sv
// SPI mode-0 slave for the console key poll: snapshots key_in at CS fall, shifts it out
// MSB first on MISO and captures the MOSI word as a command. Fully oversampled in clk.
module spi_key_slave #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   input  logic [DATA_W-1:0] key_in,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   // ---------------------------------------------------------------
   // Synchronizers, history flops and registered edge strobes
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   cs_hist;
   logic                   sclk_hist;
   logic                   cs_fall;
   logic                   cs_rise;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   mosi_bit;

   logic cs_now;
   logic sclk_now;

   assign cs_now   = cs_sync[SYNC_STAGES-1];
   assign sclk_now = sclk_sync[SYNC_STAGES-1];

   // NOTE: the CS chain resets to 0 (selected) on purpose: a CS pin already low when
   // reset releases then shows no falling edge, so the partial frame is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync   <= '0;
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_hist   <= 1'b0;
         sclk_hist <= 1'b0;
         cs_fall   <= 1'b0;
         cs_rise   <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         mosi_bit  <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_hist   <= cs_now;
         sclk_hist <= sclk_now;
         cs_fall   <= cs_hist & ~cs_now;
         cs_rise   <= ~cs_hist & cs_now;
         sclk_rise <= ~sclk_hist & sclk_now;
         sclk_fall <= sclk_hist & ~sclk_now;
         // Same pipeline age as the SCLK strobe, so it is the bit present at the rise.
         mosi_bit  <= mosi_sync[SYNC_STAGES-1];
      end
   end

   // ---------------------------------------------------------------
   // Frame FSM and shift datapath
   // ---------------------------------------------------------------
   state_t            state;
   state_t            state_n;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] tx_shift_n;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] rx_shift_n;
   logic [DATA_W-1:0] rx_data_n;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  bit_cnt_n;
   logic              rx_valid_n;
   logic              frame_err_n;
   logic              miso_n;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch; combinational logic uses blocking '='.
   always_comb begin
      state_n     = state;
      tx_shift_n  = tx_shift;
      rx_shift_n  = rx_shift;
      rx_data_n   = rx_data;
      bit_cnt_n   = bit_cnt;
      rx_valid_n  = 1'b0;
      frame_err_n = 1'b0;

      case (state)
         IDLE: begin
            if (cs_fall) begin
               tx_shift_n = key_in;
               rx_shift_n = '0;
               bit_cnt_n  = CNT_ZERO;
               state_n    = SHIFT;
            end
         end

         SHIFT: begin
            if (cs_rise) begin
               // A coincident SCLK rise is dropped: the frame is already over.
               state_n     = IDLE;
               frame_err_n = (bit_cnt != CNT_ZERO) && (bit_cnt != CNT_FULL);
            end else begin
               if (sclk_rise) begin
                  rx_shift_n = {rx_shift[DATA_W-2:0], mosi_bit};
                  if (bit_cnt != CNT_SAT) begin
                     bit_cnt_n = bit_cnt + CNT_ONE;
                  end
                  if (bit_cnt == CNT_LAST) begin
                     rx_data_n  = rx_shift_n;
                     rx_valid_n = 1'b1;
                  end
               end
               if (sclk_fall) begin
                  tx_shift_n = tx_shift << 1;
               end
            end
         end

         default: state_n = IDLE;
      endcase

      miso_n = (state_n == SHIFT) ? tx_shift_n[DATA_W-1] : 1'b0;
   end

   // NOTE: sequential state uses non-blocking '<=' so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= CNT_ZERO;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         spi_miso  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         tx_shift  <= tx_shift_n;
         rx_shift  <= rx_shift_n;
         bit_cnt   <= bit_cnt_n;
         rx_data   <= rx_data_n;
         rx_valid  <= rx_valid_n;
         frame_err <= frame_err_n;
         spi_miso  <= miso_n;
         busy      <= (state_n == SHIFT);
      end
   end

endmodule

// File: tb/tb_spi_key_slave.sv
// Directed bench for spi_key_slave: acts as a mode-0 SPI master and checks MISO bits,
// command capture, rx_valid / frame_err pulse counts, snapshot hold and reset behaviour.
`timescale 1ns/1ps
module tb_spi_key_slave;

   localparam int DW   = 16;
   localparam int HALF = 6;   // clk periods per SCLK phase

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          spi_cs = 1'b1;
   logic          spi_clk = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          spi_miso;
   logic [DW-1:0] key_in = '0;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int err_cnt = 0;

   spi_key_slave #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi_cs    (spi_cs),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .key_in    (key_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid)  valid_cnt <= valid_cnt + 1;
      if (frame_err) err_cnt   <= err_cnt + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One master frame. chg_bit / rst_bit = -1 disables the key change / mid-frame reset.
   task automatic run_frame(input logic [DW-1:0] key, input logic [DW-1:0] word,
                            input int nbits, input int chg_bit, input logic [DW-1:0] chg_key,
                            input int rst_bit, input int cs_high,
                            output logic [31:0] miso_bits, output int nvalid, output int nerr,
                            output logic busy_mid, output logic [DW+3:0] rst_obs);
      int v0;
      int e0;
      miso_bits = '0;
      busy_mid  = 1'b0;
      rst_obs   = '0;
      key_in    = key;
      v0        = valid_cnt;
      e0        = err_cnt;
      spi_cs    = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_bit) begin
            rst = 1'b1;
            wait_clk(3);
            rst_obs = {busy, spi_miso, rx_valid, frame_err, rx_data};
            rst = 1'b0;
            v0 = valid_cnt;
            e0 = err_cnt;
         end
         spi_mosi = (i < DW) ? word[DW-1-i] : 1'b0;
         wait_clk(HALF);
         miso_bits = {miso_bits[30:0], spi_miso};
         if (i == nbits / 2) busy_mid = busy;
         spi_clk = 1'b1;
         wait_clk(HALF);
         spi_clk = 1'b0;
         if (i == chg_bit) key_in = chg_key;
      end
      wait_clk(HALF);
      spi_cs = 1'b1;
      wait_clk(cs_high);
      nvalid = valid_cnt - v0;
      nerr   = err_cnt - e0;
   endtask

   logic [31:0]   bits;
   int            nv;
   int            ne;
   logic          bm;
   logic [DW+3:0] ro;

   task automatic test_reset();
      wait_clk(3);
      checks++;
      if ({busy, spi_miso, rx_valid, frame_err, rx_data} !== '0) begin
         errors++;
         $display("FAIL reset_in got %h exp 0", {busy, spi_miso, rx_valid, frame_err, rx_data});
      end
      rst = 1'b0;
      wait_clk(8);
      checks++;
      if ({busy, spi_miso, rx_valid, frame_err, rx_data} !== '0 || valid_cnt != 0 || err_cnt != 0) begin
         errors++;
         $display("FAIL reset_after got %h v=%0d e=%0d exp 0", {busy, spi_miso, rx_valid, frame_err, rx_data},
                  valid_cnt, err_cnt);
      end
   endtask

   task automatic test_basic_read();
      run_frame(16'h0004, 16'hA55A, 16, -1, '0, -1, 10, bits, nv, ne, bm, ro);
      checks++;
      if (bits[15:0] !== 16'h0004) begin
         errors++; $display("FAIL basic_miso got %h exp 0004", bits[15:0]);
      end
      checks++;
      if (rx_data !== 16'hA55A) begin
         errors++; $display("FAIL basic_rx_data got %h exp a55a", rx_data);
      end
      checks++;
      if (nv != 1 || ne != 0) begin
         errors++; $display("FAIL basic_pulses got valid=%0d err=%0d exp 1/0", nv, ne);
      end
      checks++;
      if (bm !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_busy got mid=%b end=%b exp 1/0", bm, busy);
      end
   endtask

   task automatic test_snapshot_hold();
      run_frame(16'h8000, 16'h0001, 16, 3, 16'h0001, -1, 10, bits, nv, ne, bm, ro);
      checks++;
      if (bits[15:0] !== 16'h8000) begin
         errors++; $display("FAIL snapshot_miso got %h exp 8000", bits[15:0]);
      end
      checks++;
      if (rx_data !== 16'h0001 || nv != 1) begin
         errors++; $display("FAIL snapshot_rx got %h valid=%0d exp 0001/1", rx_data, nv);
      end
   endtask

   task automatic test_short_frame();
      run_frame(16'h0000, 16'h1234, 9, -1, '0, -1, 10, bits, nv, ne, bm, ro);
      checks++;
      if (ne != 1 || nv != 0) begin
         errors++; $display("FAIL short_pulses got err=%0d valid=%0d exp 1/0", ne, nv);
      end
      checks++;
      if (rx_data !== 16'h0001) begin
         errors++; $display("FAIL short_rx_hold got %h exp 0001", rx_data);
      end
      run_frame(16'h0010, 16'h0F0F, 16, -1, '0, -1, 10, bits, nv, ne, bm, ro);
      checks++;
      if (bits[15:0] !== 16'h0010 || rx_data !== 16'h0F0F || nv != 1 || ne != 0) begin
         errors++;
         $display("FAIL short_recover got miso=%h rx=%h v=%0d e=%0d exp 0010/0f0f/1/0", bits[15:0], rx_data, nv, ne);
      end
   endtask

   task automatic test_cs_blip();
      run_frame(16'h5555, 16'h0000, 0, -1, '0, -1, 10, bits, nv, ne, bm, ro);
      checks++;
      if (nv != 0 || ne != 0 || rx_data !== 16'h0F0F) begin
         errors++; $display("FAIL blip got v=%0d e=%0d rx=%h exp 0/0/0f0f", nv, ne, rx_data);
      end
   endtask

   task automatic test_overlong();
      run_frame(16'hFFFF, 16'hC3C3, 20, -1, '0, -1, 10, bits, nv, ne, bm, ro);
      checks++;
      if (bits !== 32'h000F_FFF0) begin
         errors++; $display("FAIL overlong_miso got %h exp 000ffff0", bits);
      end
      checks++;
      if (nv != 1 || ne != 1) begin
         errors++; $display("FAIL overlong_pulses got valid=%0d err=%0d exp 1/1", nv, ne);
      end
      checks++;
      if (rx_data !== 16'hC3C3) begin
         errors++; $display("FAIL overlong_rx got %h exp c3c3", rx_data);
      end
   endtask

   task automatic test_reset_mid_frame();
      run_frame(16'h7777, 16'h9999, 16, -1, '0, 5, 10, bits, nv, ne, bm, ro);
      checks++;
      if (ro !== '0) begin
         errors++; $display("FAIL midrst_outputs got %h exp 0", ro);
      end
      checks++;
      if (nv != 0 || ne != 0 || rx_data !== 16'h0000 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_after got v=%0d e=%0d rx=%h busy=%b exp 0/0/0/0", nv, ne, rx_data, busy);
      end
      checks++;
      if (bits[10:0] !== 11'h000) begin
         errors++; $display("FAIL midrst_miso got %h exp 000", bits[10:0]);
      end
      run_frame(16'h00A5, 16'h5A5A, 16, -1, '0, -1, 10, bits, nv, ne, bm, ro);
      checks++;
      if (bits[15:0] !== 16'h00A5 || rx_data !== 16'h5A5A || nv != 1 || ne != 0) begin
         errors++;
         $display("FAIL midrst_recover got miso=%h rx=%h v=%0d e=%0d exp 00a5/5a5a/1/0", bits[15:0], rx_data, nv, ne);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] bits2;
      int          nv2;
      int          ne2;
      run_frame(16'h0100, 16'h1111, 16, -1, '0, -1, 4, bits, nv, ne, bm, ro);
      run_frame(16'h0200, 16'h2222, 16, -1, '0, -1, 10, bits2, nv2, ne2, bm, ro);
      checks++;
      if (bits[15:0] !== 16'h0100) begin
         errors++; $display("FAIL b2b_first got %h exp 0100", bits[15:0]);
      end
      checks++;
      if (bits2[15:0] !== 16'h0200) begin
         errors++; $display("FAIL b2b_second got %h exp 0200", bits2[15:0]);
      end
      checks++;
      if (nv + nv2 != 2 || ne + ne2 != 0 || rx_data !== 16'h2222) begin
         errors++;
         $display("FAIL b2b_pulses got valid=%0d err=%0d rx=%h exp 2/0/2222", nv + nv2, ne + ne2, rx_data);
      end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_snapshot_hold();
      test_short_frame();
      test_cs_blip();
      test_overlong();
      test_reset_mid_frame();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
